// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit-side byte FIFO between the register block and the UART transmit
//   shifter. Writes come from the register block. The read port presents the
//   head byte in first-word fall-through form over a valid/ready handshake.
//   The block also reports occupancy, a sticky overflow flag and a TX
//   watermark interrupt.
//
// Parameters
//   DEPTH : number of byte entries (power of 2, >= 2)
//   AW    : pointer index width, derived from DEPTH
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   fifo_flush    : single-cycle pulse that empties the FIFO (beats push/pop)
//   wr_valid      : write strobe
//   wr_data       : byte to enqueue
//   wr_ready      : FIFO can accept a write (not full)
//   tx_valid      : head byte available (not empty)
//   tx_data       : head byte, 0 when empty
//   tx_ready      : transmitter accepts the head byte
//   cfg_thresh    : watermark level for irq_txwm
//   ovf_clr       : clears status_ovf
//   status_count  : occupancy, 0..DEPTH
//   status_empty  : occupancy == 0
//   status_full   : occupancy == DEPTH
//   status_ovf    : sticky, set when a write was dropped
//   irq_txwm      : high while status_count <= cfg_thresh
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fifo_flush,
   input  logic          wr_valid,
   input  logic [7:0]    wr_data,
   output logic          wr_ready,
   output logic          tx_valid,
   output logic [7:0]    tx_data,
   input  logic          tx_ready,
   input  logic [AW:0]   cfg_thresh,
   input  logic          ovf_clr,
   output logic [AW:0]   status_count,
   output logic          status_empty,
   output logic          status_full,
   output logic          status_ovf,
   output logic          irq_txwm
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wp;
   logic [AW:0] r_rp;
   logic        r_ovf;

   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_drop;

   // Pointers carry one extra wrap bit, so equal indices mean either empty
   // (wrap bits equal) or full (wrap bits differ).
   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

   // Accept/drop decisions use registered full/empty only, so a pop in the
   // same cycle does not rescue a write to a full FIFO.
   assign w_push = wr_valid && !w_full && !fifo_flush;
   assign w_pop  = tx_ready && !w_empty && !fifo_flush;
   assign w_drop = wr_valid && w_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_ovf <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         if (fifo_flush) begin
            r_wp <= '0;
            r_rp <= '0;
         end else begin
            if (w_push) r_wp <= r_wp + PTR_ONE;
            if (w_pop)  r_rp <= r_rp + PTR_ONE;
         end
         // Set beats clear when both happen in the same cycle.
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

   // NOTE: the storage array has no reset; stale entries are never visible
   // because tx_data is forced to 0 when empty and reads only follow pushes.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= wr_data;
   end

   assign status_count = r_wp - r_rp;
   assign status_empty = w_empty;
   assign status_full  = w_full;
   assign status_ovf   = r_ovf;
   assign wr_ready     = !w_full;
   assign tx_valid     = !w_empty;
   assign tx_data      = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];
   assign irq_txwm     = (status_count <= cfg_thresh);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo (DEPTH = 16). The stimulus driver
//   keeps a behavioural model (occupancy count, overflow flag) and pushes each
//   accepted byte into a scoreboard queue. A separate monitor pops the queue
//   whenever the DUT completes a tx handshake and compares the byte. It also
//   checks that an offered byte is held while the transmitter stalls.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fifo_flush;
   logic          wr_valid;
   logic [7:0]    wr_data;
   logic          wr_ready;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          tx_ready;
   logic [AW:0]   cfg_thresh;
   logic          ovf_clr;
   logic [AW:0]   status_count;
   logic          status_empty;
   logic          status_full;
   logic          status_ovf;
   logic          irq_txwm;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_flush   (fifo_flush),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .cfg_thresh   (cfg_thresh),
      .ovf_clr      (ovf_clr),
      .status_count (status_count),
      .status_empty (status_empty),
      .status_full  (status_full),
      .status_ovf   (status_ovf),
      .irq_txwm     (irq_txwm)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   int         m_count = 0;
   bit         m_ovf   = 1'b0;
   logic [7:0] exp_q[$];
   int         n_push = 0;
   int         n_pop  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare every registered-state output with the model.
   task automatic check_status();
      check("count",    32'(status_count), 32'(m_count));
      check("empty",    32'(status_empty), 32'(m_count == 0));
      check("full",     32'(status_full),  32'(m_count == DEPTH));
      check("wr_ready", 32'(wr_ready),     32'(m_count != DEPTH));
      check("tx_valid", 32'(tx_valid),     32'(m_count != 0));
      check("ovf",      32'(status_ovf),   32'(m_ovf));
      check("irq_txwm", 32'(irq_txwm),     32'(m_count <= int'(cfg_thresh)));
      if (m_count == 0) check("tx_data_empty", 32'(tx_data), 32'h0);
   endtask

   // One clock cycle of stimulus. The model is updated from the pre-edge
   // occupancy, outputs are checked 1 ns after the edge.
   task automatic step(input logic wv, input logic [7:0] wd, input logic tr,
                       input logic fl, input logic oc);
      bit full;
      bit empty;
      bit push;
      bit pop;
      wr_valid   = wv;
      wr_data    = wd;
      tx_ready   = tr;
      fifo_flush = fl;
      ovf_clr    = oc;
      full  = (m_count == DEPTH);
      empty = (m_count == 0);
      if (wv && full) m_ovf = 1'b1;
      else if (oc)    m_ovf = 1'b0;
      if (fl) begin
         m_count = 0;
      end else begin
         push = wv && !full;
         pop  = tr && !empty;
         if (push) begin
            exp_q.push_back(wd);
            n_push++;
         end
         if (pop) n_pop++;
         m_count = m_count + int'(push) - int'(pop);
      end
      @(posedge clk);
      if (fl) exp_q.delete();
      #1;
      wr_valid   = 1'b0;
      tx_ready   = 1'b0;
      fifo_flush = 1'b0;
      ovf_clr    = 1'b0;
      check_status();
   endtask

   task automatic drain();
      while (m_count > 0) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: compares handshaken bytes against the scoreboard and checks
   // that a stalled offer is held unchanged.
   initial begin
      bit         hold_prev = 1'b0;
      logic [7:0] hold_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hold_prev) begin
               check("hold_valid", 32'(tx_valid), 32'h1);
               check("hold_data",  32'(tx_data),  32'(hold_data));
            end
            if (tx_valid && tx_ready && !fifo_flush) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL pop_unexpected: got %0h expected no byte", tx_data);
               end else begin
                  check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
               end
            end
            hold_prev = tx_valid && !tx_ready && !fifo_flush;
            hold_data = tx_data;
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      fifo_flush = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = 8'h00;
      tx_ready   = 1'b0;
      ovf_clr    = 1'b0;
      cfg_thresh = 5'd4;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state.
      check_status();
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_irq",     32'(irq_txwm), 32'h1);

      // Order and latency.
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      check("first_valid", 32'(tx_valid), 32'h1);
      check("first_data",  32'(tx_data),  32'h55);
      step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
      check("count3", 32'(status_count), 32'd3);
      repeat (3) begin
         step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      check("order_empty", 32'(status_empty), 32'h1);

      // Full and overflow.
      for (int i = 0; i <= 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         if (i == 15) begin
            check("full16",  32'(status_full), 32'h1);
            check("wrrdy16", 32'(wr_ready),    32'h0);
         end
      end
      check("ovf_set", 32'(status_ovf), 32'h1);
      drain();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ovf_clr", 32'(status_ovf), 32'h0);

      // Simultaneous push and pop at count 5, then at full.
      for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h30, 1'b1, 1'b0, 1'b0);
      check("pp_count5", 32'(status_count), 32'd5);
      check("pp_head",   32'(tx_data),      32'h21);
      while (m_count < DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
      check("pp_full_count", 32'(status_count), 32'd15);
      check("pp_full_ovf",   32'(status_ovf),   32'h1);
      drain();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Randomized traffic with several pointer wraps.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) cfg_thresh = 5'($urandom_range(0, 31));
         step(1'($urandom_range(0, 99) < 55), 8'($urandom),
              1'($urandom_range(0, 99) < 50),
              1'($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 29) == 0));
         check("count_le_depth", 32'(status_count <= 5'd16), 32'h1);
      end
      drain();
      check("wrap_pushes", 32'(n_push >= 3 * DEPTH), 32'h1);

      // Abandon contents with an asynchronous reset between edges.
      for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(tx_valid),     32'h0);
      check("async_rst_count", 32'(status_count), 32'h0);
      check("async_rst_data",  32'(tx_data),      32'h0);
      m_count = 0;
      m_ovf   = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_status();

      // Flush and watermark.
      cfg_thresh = 5'd4;
      for (int i = 0; i < 8; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
      check("wm_at8", 32'(irq_txwm), 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("wm_at4", 32'(irq_txwm), 32'h1);
      step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      check("flush_count", 32'(status_count), 32'h0);
      check("flush_valid", 32'(tx_valid),     32'h0);
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      check("post_flush_head", 32'(tx_data), 32'h11);
      drain();
      check("sb_empty", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
